// File: rtl/dram_model.sv
// dram_model: single-bank DRAM responder with open-page row buffer and
// precharge/activate/column-access timing behind a ready/re/we handshake.
module dram_model #(
  parameter int ADDR_BITS = 10,
  parameter int COL_BITS  = 4,
  parameter int T_RP      = 3,
  parameter int T_RCD     = 3,
  parameter int T_CAS     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] addr,
  input  logic [63:0] din,
  output logic [63:0] dout,
  input  logic        re,
  input  logic        we,
  output logic        ready
);
  localparam int RB   = ADDR_BITS - COL_BITS;
  localparam int MAXT = (T_RP > T_RCD) ? ((T_RP > T_CAS) ? T_RP : T_CAS) : ((T_RCD > T_CAS) ? T_RCD : T_CAS);
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  typedef enum logic [1:0] {IDLE, PRECHARGE, ACTIVATE, ACCESS} state_t;
  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx, last;
  logic                   end_ph, acc_done, wr, open_valid;
  logic [ADDR_BITS-1:0]   idx;
  logic [63:0]            wdata;
  logic [RB-1:0]          open_row, req_row;
  logic [63:0]            mem [2**ADDR_BITS];
  assign ready   = state == IDLE;
  assign req_row = addr[ADDR_BITS-1:COL_BITS];
  always_comb begin
    last     = state == PRECHARGE ? CW'(T_RP - 1) : state == ACTIVATE ? CW'(T_RCD - 1) : CW'(T_CAS - 1);
    end_ph   = cnt == last;
    acc_done = state == ACCESS && end_ph;
    state_nx = state;
    cnt_nx   = end_ph ? '0 : cnt + 1'b1;
    if (state == IDLE) begin
      cnt_nx = '0;
      if (re || we)
        state_nx = (open_valid && open_row == req_row) ? ACCESS : open_valid ? PRECHARGE : ACTIVATE;
    end else if (end_ph) begin
      state_nx = state == PRECHARGE ? ACTIVATE : state == ACTIVATE ? ACCESS : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      open_valid <= 1'b0;
      open_row   <= '0;
      dout       <= '0;
      idx        <= '0;
      wdata      <= '0;
      wr         <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ready && (re || we)) begin
        idx   <= addr[ADDR_BITS-1:0];
        wdata <= din;
        wr    <= we;
      end
      if (state == PRECHARGE && end_ph) open_valid <= 1'b0;
      if (state == ACTIVATE && end_ph) begin
        open_valid <= 1'b1;
        open_row   <= idx[ADDR_BITS-1:COL_BITS];
      end
      if (acc_done && !wr) dout <= mem[idx];
    end
  end
  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk)
    if (acc_done && wr) mem[idx] <= wdata;
endmodule

// File: tb/tb_dram_model.sv
// tb_dram_model: directed and randomized requests checked against a
// row-buffer timing and storage reference model.
module tb_dram_model;
  logic        clk = 0, rst = 1, re = 0, we = 0, ready;
  logic [63:0] addr = 0, din = 0, dout;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] mm [1024];
  bit          known [1024];
  bit          ov = 0;
  int          orow = 0;
  logic [63:0] dout_exp = 0;
  bit          dout_known = 1;

  dram_model dut (.clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we), .ready(ready));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d, input bit noise);
    int lat = 0, expl, i, row;
    i   = int'(a[9:0]);
    row = i / 16;
    expl = (ov && orow == row) ? 2 : (!ov ? 5 : 8);
    ov = 1;
    orow = row;
    if (w) begin
      mm[i] = d;
      known[i] = 1;
    end else if (r) begin
      dout_known = known[i];
      dout_exp = mm[i];
    end
    @(negedge clk);
    re = r; we = w; addr = a; din = d;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      re   = noise ? 1'($urandom) : 1'b0;
      we   = noise ? 1'($urandom) : 1'b0;
      addr = {$urandom(), $urandom()};
      din  = {$urandom(), $urandom()};
    end
    re = 0; we = 0;
    check(r && !w ? "rd_lat" : "wr_lat", 64'(lat), 64'(expl));
    if (dout_known) check("dout", dout, dout_exp);
  endtask

  initial begin
    logic [63:0] a, d;
    for (int k = 0; k < 1024; k++) known[k] = 0;
    #2 rst = 0;
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_dout", dout, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1;
    op(0, 1, 64'd1, 64'h0123456789abcdef, 0);
    op(1, 0, 64'd1, 64'd0, 0);
    op(0, 1, 64'd257, 64'd123, 0);
    op(1, 0, 64'd1025, 64'd0, 0);
    op(1, 1, 64'd2, 64'd5, 0);
    op(1, 0, 64'd2, 64'd0, 1);
    for (int k = 0; k < 200; k++) begin
      a = {$urandom(), $urandom()};
      a[9:0] = {6'($urandom_range(0, 3)), 4'($urandom)};
      d = {$urandom(), $urandom()};
      case ($urandom_range(0, 2))
        0: op(1, 0, a, d, 1'($urandom));
        1: op(0, 1, a, d, 1'($urandom));
        default: op(1, 1, a, d, 1'($urandom));
      endcase
    end
    op(0, 1, 64'd300, 64'hdead_beef_0000_0300, 0);
    op(1, 0, 64'd1, 64'd0, 0);
    @(negedge clk);
    re = 0; we = 1; addr = 64'd300; din = 64'h1111_2222_3333_4444;
    @(posedge clk);
    @(negedge clk);
    we = 0;
    rst = 0;
    #1;
    check("mid_rst_ready", {63'd0, ready}, 64'd1);
    check("mid_rst_dout", dout, 64'd0);
    ov = 0;
    dout_exp = 0;
    dout_known = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    op(1, 0, 64'd300, 64'd0, 0);
    check("discarded_wr", dout, 64'hdead_beef_0000_0300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dram_model.md
DRAM_MODEL -- requirements
Module: dram_model

Interface
REQ-001 Parameter ADDR_BITS, default 10, meaning log2 of storage depth in 64-bit words.
REQ-002 Parameter COL_BITS, default 4, meaning low address bits selecting a column within a row.
REQ-003 Parameter T_RP, default 3, meaning precharge cycles (>=1).
REQ-004 Parameter T_RCD, default 3, meaning activate cycles (>=1).
REQ-005 Parameter T_CAS, default 2, meaning column access cycles (>=1).
REQ-006 Port clk  input  1  sole clock, rising edge.
REQ-007 Port rst  input  1  reset, asynchronous, active-low: asserted when rst=0.
REQ-008 Port addr  input  64  word address of request.
REQ-009 Port din  input  64  write data.
REQ-010 Port dout  output  64  read data.
REQ-011 Port re  input  1  read request.
REQ-012 Port we  input  1  write request.
REQ-013 Port ready  output  1  high = idle and able to accept a request.

Function
REQ-014 Responder end of the 64-bit addr/din/dout/re/we/ready memory protocol; drop-in replacement for the existing flat-latency RAM, with row-buffer timing.
REQ-015 Acceptance: request accepted at a rising edge where ready=1 and (re|we)=1; addr, din, re, we latched at that edge.
REQ-016 re and we both high at acceptance: treated as write only; dout unchanged.
REQ-017 re/we while ready=0 ignored; no queuing, no side effects.
REQ-018 Storage: 2^ADDR_BITS words, index addr[ADDR_BITS-1:0]; addr upper bits ignored (aliasing).
REQ-019 Row = index[ADDR_BITS-1:COL_BITS]; one open-row register plus open-valid bit.
REQ-020 States: IDLE, PRECHARGE, ACTIVATE, ACCESS; ready=1 only in IDLE.
REQ-021 From IDLE on acceptance: open row hit -> ACCESS; no row open -> ACTIVATE; other row open -> PRECHARGE.
REQ-022 PRECHARGE lasts T_RP cycles, clears open-valid, then ACTIVATE.
REQ-023 ACTIVATE lasts T_RCD cycles, loads open row from latched addr and sets open-valid, then ACCESS.
REQ-024 ACCESS lasts T_CAS cycles, then IDLE; row stays open (open-page policy).
REQ-025 Latency L (ready low for exactly L cycles after acceptance edge N, high again after edge N+L): hit T_CAS; closed T_RCD+T_CAS; miss T_RP+T_RCD+T_CAS.
REQ-026 Write: storage updated at the final ACCESS edge (N+L) with latched din.
REQ-027 Read: dout loaded at edge N+L from storage at latched index; held until the next completed read.
REQ-028 A new request may be accepted at the first edge where ready=1 (back-to-back, no dead cycle).
REQ-029 Phase counter wide enough for max(T_RP,T_RCD,T_CAS); no wrap within a phase.

Reset
REQ-030 On rst=0, immediately and regardless of state: state IDLE, ready=1, dout=0, open-valid=0, counter=0.
REQ-031 Reset mid-operation abandons the access: pending write not committed, dout not updated.
REQ-032 Storage contents not reset; contents persist across reset.
REQ-033 Requests sampled only while rst=1.

Verification (defaults)
REQ-034 Reset, write addr 1 din 0x0123456789abcdef -> ready low 5 cycles (closed), then high.
REQ-035 Then read addr 1 -> ready low 2 cycles (hit); dout=0x0123456789abcdef.
REQ-036 Then write addr 257 din 123 -> ready low 8 cycles (row 16 vs open row 0); read addr 1025 -> 8 cycles, dout=0x0123456789abcdef (alias of 1).
REQ-037 re=we=1 addr 2 din 5 -> treated as write, dout unchanged; then read addr 2 -> dout=5; re pulsed while ready=0 -> no effect on latency or dout.
REQ-038 rst=0 during PRECHARGE of write to addr 300 -> ready=1 and dout=0 without a clock edge; then read addr 300 -> latency 5 (closed), old contents returned (write discarded).
